// File: rtl/lif_neuron_array.sv
// Array of leaky integrate-and-fire neurons sharing one sequential leak/fire datapath.
// Define LIF_SPARSE_CNT_EN to count dropped zero-current events on sparse_cnt.
module lif_neuron_array #(
    parameter int N_NEURONS    = 4,
    parameter int DATA_W       = 8,
    parameter int THRESH       = 200,
    parameter int LEAK_SHIFT   = 1,
    parameter int REFRAC_STEPS = 2,
    localparam int IDX_W       = $clog2(N_NEURONS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IDX_W-1:0]     in_nid,
    input  logic [DATA_W-1:0]    in_current,
    input  logic                 step,
    output logic                 busy,
    output logic                 spike_valid,
    output logic [N_NEURONS-1:0] spike_vec,
    input  logic [IDX_W-1:0]     rd_nid,
    output logic [DATA_W-1:0]    rd_state,
    output logic [15:0]          sparse_cnt
);

    localparam int DEPTH = 1 << IDX_W;
    localparam int REF_W = (REFRAC_STEPS > 0) ? $clog2(REFRAC_STEPS + 1) : 1;

    typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

    state_t              state;
    logic [IDX_W-1:0]    idx;
    logic                pending;
    logic [DATA_W-1:0]   membrane [DEPTH];
    logic [REF_W-1:0]    refrac   [DEPTH];
    logic [DEPTH-1:0]    nid_ok;
    logic [DEPTH-1:0]    shadow;
    logic [DEPTH-1:0]    shadow_next;

    logic                accept;
    logic                apply_evt;
    logic [DATA_W:0]     sum;
    logic [DATA_W-1:0]   sat_v;
    logic [DATA_W-1:0]   cur_v;
    logic [REF_W-1:0]    cur_r;
    logic [DATA_W-1:0]   leak_v;
    logic                fire;

    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);
    assign accept   = in_valid & in_ready;

    // Index space is rounded up to a power of two; out-of-range ids are accepted but ignored.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) nid_ok[i] = (i < N_NEURONS);
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        sum         = {1'b0, membrane[in_nid]} + {1'b0, in_current};
        sat_v       = sum[DATA_W] ? '1 : sum[DATA_W-1:0];
        apply_evt   = accept && (in_current != '0) && nid_ok[in_nid] && (refrac[in_nid] == '0);
        cur_v       = membrane[idx];
        cur_r       = refrac[idx];
        fire        = (cur_r == '0) && (cur_v >= DATA_W'(THRESH));
        leak_v      = cur_v - (cur_v >> LEAK_SHIFT);
        shadow_next = shadow;
        shadow_next[idx] = fire;
    end

    // NOTE: membranes and refractory counters are flops with architectural reset state,
    // so they are cleared in the async reset branch rather than left as uninitialised RAM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            idx         <= '0;
            pending     <= 1'b0;
            shadow      <= '0;
            spike_vec   <= '0;
            spike_valid <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                membrane[i] <= '0;
                refrac[i]   <= '0;
            end
        end else begin
            // NOTE: sequential state uses non-blocking assignments only.
            spike_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (apply_evt) membrane[in_nid] <= sat_v;
                    if (step) begin
                        state  <= SWEEP;
                        idx    <= '0;
                        shadow <= '0;
                    end
                end
                SWEEP: begin
                    if (step) pending <= 1'b1;
                    if (cur_r != '0) begin
                        membrane[idx] <= '0;
                        refrac[idx]   <= cur_r - REF_W'(1);
                    end else if (fire) begin
                        membrane[idx] <= '0;
                        refrac[idx]   <= REF_W'(REFRAC_STEPS);
                    end else begin
                        membrane[idx] <= leak_v;
                    end
                    shadow <= shadow_next;
                    if (idx == IDX_W'(N_NEURONS - 1)) begin
                        state       <= DONE;
                        spike_vec   <= shadow_next[N_NEURONS-1:0];
                        spike_valid <= 1'b1;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                DONE: begin
                    pending <= 1'b0;
                    if (pending || step) begin
                        state  <= SWEEP;
                        idx    <= '0;
                        shadow <= '0;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_state <= '0;
        else        rd_state <= membrane[rd_nid];
    end

`ifdef LIF_SPARSE_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sparse_cnt <= '0;
        end else if (accept && (in_current == '0) && (sparse_cnt != 16'hFFFF)) begin
            sparse_cnt <= sparse_cnt + 16'd1;
        end
    end
`else
    assign sparse_cnt = '0;
`endif

endmodule
